// File: rtl/serial_word_packer.sv
// ============================================================================
// Module   : serial_word_packer
// Function : Packs a serial bitstream, LSB first, into DATA_WIDTH-bit words
//            with valid/ready handshakes on both the input and output sides.
//            Optional synchronous clear port: define SERIAL_WORD_PACKER_CLR_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_word_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
`ifdef SERIAL_WORD_PACKER_CLR_EN
    input  logic                  clr,
`endif
    input  logic                  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] c_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_acc;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_out_free;
    logic                  w_load;
    logic                  w_clr;
    logic [DATA_WIDTH-1:0] w_acc_next;

`ifdef SERIAL_WORD_PACKER_CLR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    assign din_ready  = (r_cnt != c_FULL);
    assign w_accept   = din_valid && din_ready;
    assign w_complete = (r_cnt == c_FULL) || ((r_cnt == c_LAST) && w_accept);
    assign w_out_free = !r_dout_valid || dout_ready;
    assign w_load     = w_complete && w_out_free && !w_clr;

    // Accumulator with the bit being accepted this cycle already merged in,
    // so a word finishing on this edge can be loaded straight into dout.
    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (w_accept && (r_cnt == CW'(i))) begin
                w_acc_next[i] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_load) begin
                r_acc <= w_acc_next;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_load) begin
                r_dout       <= w_acc_next;
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

`default_nettype wire

// File: doc/serial_word_packer.md
SERIAL_WORD_PACKER -- requirements
Module: serial_word_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the number of bits per assembled word (minimum 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port din  input  1  serial data bit.
REQ-005 SHALL have port din_valid  input  1  din carries a valid bit this cycle.
REQ-006 SHALL have port din_ready  output  1  block accepts a bit this cycle.
REQ-007 SHALL have port dout  output  DATA_WIDTH  assembled word; feeds the downstream palindrome detector din.
REQ-008 SHALL have port dout_valid  output  1  dout holds a complete word.
REQ-009 SHALL have port dout_ready  input  1  consumer takes dout this cycle.

Function
REQ-010 SHALL contain an accumulator (DATA_WIDTH bits), a bit counter (0..DATA_WIDTH), an output word register and a dout_valid flag.
REQ-011 SHALL accept a bit on a rising edge only when din_valid and din_ready are both 1: acc[cnt] <= din, cnt <= cnt+1.
REQ-012 SHALL pack LSB-first: the first accepted bit of a word lands in dout[0], the last in dout[DATA_WIDTH-1].
REQ-013 SHALL drive din_ready = 1 when cnt < DATA_WIDTH and 0 when cnt == DATA_WIDTH (complete word stalled in accumulator); combinational from state only.
REQ-014 SHALL treat a word as complete on an edge when cnt == DATA_WIDTH, or when cnt == DATA_WIDTH-1 and a bit is accepted on that edge.
REQ-015 SHALL load a complete word into dout, set dout_valid and clear cnt to 0 on the same edge, when dout_valid == 0 or dout_ready == 1.
REQ-016 SHALL otherwise keep the complete word in the accumulator, with cnt == DATA_WIDTH, until the output register frees.
REQ-017 SHALL assert dout_valid in the cycle immediately after the edge that accepts the last bit, when the output register is free (zero extra latency).
REQ-018 SHALL clear dout_valid on an edge where dout_valid and dout_ready are 1 and no new word loads.
REQ-019 SHALL keep dout_valid at 1 with the new word when drain and load occur on the same edge (no bubble).
REQ-020 SHALL hold dout stable while dout_valid == 1 and dout_ready == 0.
REQ-021 SHALL sustain one bit per cycle indefinitely while dout_ready stays 1.
REQ-022 SHALL ignore din whenever din_valid == 0 or din_ready == 0 (no state change from that bit).

Reset
REQ-023 SHALL, while resetn == 0, force cnt = 0, acc = 0, dout = 0 and dout_valid = 0; din_ready therefore reads 1.
REQ-024 SHALL discard any partial word and any pending output word on reset assertion mid-operation; the first bit accepted after release becomes bit 0.

Configuration
REQ-025 SHALL, with macro SERIAL_WORD_PACKER_CLR_EN defined, add an input port clr (1 bit, synchronous, active-high).
REQ-026 SHALL, with SERIAL_WORD_PACKER_CLR_EN defined, set cnt = 0 and acc = 0 on an edge where clr == 1, leaving dout and dout_valid unchanged.
REQ-027 SHALL, with SERIAL_WORD_PACKER_CLR_EN defined, give clr priority over bit acceptance and word transfer on the same edge; the coincident bit is discarded.
REQ-028 SHALL, without SERIAL_WORD_PACKER_CLR_EN, omit the clr port entirely; behaviour is then REQ-010..REQ-024 only.

Verification (DATA_WIDTH=8)
REQ-029 SHALL cover: assert resetn=0 after 3 accepted bits -> dout_valid=0, din_ready=1; the next 8 bits 0xFF form dout=8'hFF.
REQ-030 SHALL cover: bits 1,0,1,1,0,0,0,1 on consecutive cycles, dout_ready=1 -> dout=8'h8D, dout_valid high exactly one cycle, starting the cycle after the 8th edge.
REQ-031 SHALL cover: dout_ready=0, send words 8'hA5 then 8'h3C -> dout holds 8'hA5 and din_ready=0 after bit 16; raise dout_ready one cycle -> dout=8'h3C, dout_valid stays 1, din_ready=1.
REQ-032 SHALL cover: three words 8'h81, 8'h00, 8'h7E with random din_valid gaps and dout_ready=1 -> exactly three dout words, in order and correct.
REQ-033 SHALL cover (macro defined): clr after 5 bits, with din_valid=1 on the clr cycle -> that bit and the partial word are dropped; the next 8 bits 8'h5A yield dout=8'h5A.
